truth_table_sweeper: RTL and testbench

- Sequential stimulus/capture engine for the combinational logic modules the synthesizer consumes.
- Drives every input combination onto a device under test and waits a programmable settle time before sampling the single response bit.
- Assembles the 2^N-entry truth table; it reads a function back, where the logic modules define one.
- Used in benches and on-chip self-check wrappers to confirm a synthesized netlist matches its specification.

---
 rtl/truth_table_pkg.sv | 25 ++
 rtl/truth_table_sweeper_settle_timer.sv | 41 ++++
 rtl/truth_table_sweeper.sv | 155 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_pkg;

  localparam int DEF_NUM_INPUTS    = 32'sd3;
  localparam int DEF_SETTLE_CYCLES = 32'sd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int tt_width(input int n);
    return 32'sd1 << n;
  endfunction

  // Settle counter must hold SETTLE_CYCLES and is never narrower than one bit.
  function automatic int settle_w(input int s);
    int w;
    w = $clog2(s + 32'sd1);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable saturating down-counter that paces how long each pattern is held.
module settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             expired_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next count: load wins, otherwise decrement and stop at zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - WIDTH'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign expired_o = (value_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input pattern onto a combinational DUT and captures its truth table.
// Define TRUTH_TABLE_COMPARE_EN to add expected_tt/match comparison against a golden table.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int NUM_INPUTS    = DEF_NUM_INPUTS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            resp_in,
  output logic [NUM_INPUTS-1:0]           stim,
  output logic                            busy,
  output logic                            done,
  output logic                            tt_valid,
  output logic [tt_width(NUM_INPUTS)-1:0] truth_table
`ifdef TRUTH_TABLE_COMPARE_EN
  ,
  input  logic [tt_width(NUM_INPUTS)-1:0] expected_tt,
  output logic                            match
`endif
);

  localparam int                    TT_W = tt_width(NUM_INPUTS);
  localparam int                    CW   = settle_w(SETTLE_CYCLES);
  localparam logic [NUM_INPUTS-1:0] LAST = NUM_INPUTS'(TT_W - 32'sd1);
  localparam logic [CW-1:0]         LOAD = CW'(SETTLE_CYCLES);
  localparam state_e                HOLD = (SETTLE_CYCLES == 32'sd0) ? SAMPLE : SETTLE;

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] stim_q, stim_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tv_q, tv_d;
  logic [TT_W-1:0]       tt_q, tt_d;
  logic                  tmr_load_s;
  logic                  tmr_dec_s;
  logic [CW-1:0]         tmr_value_s;
  logic                  tmr_expired_s;
`ifdef TRUTH_TABLE_COMPARE_EN
  logic                  match_q, match_d;
`endif

  settle_timer #(.WIDTH(CW)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .dec_i      (tmr_dec_s),
    .load_val_i (LOAD),
    .value_o    (tmr_value_s),
    .expired_o  (tmr_expired_s)
  );

  // Sweep sequencing: next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tv_d       = tv_q;
    tt_d       = tt_q;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
`ifdef TRUTH_TABLE_COMPARE_EN
    match_d    = match_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          stim_d     = '0;
          busy_d     = 1'b1;
          tv_d       = 1'b0;
          tt_d       = '0;
          tmr_load_s = 1'b1;
          state_d    = HOLD;
`ifdef TRUTH_TABLE_COMPARE_EN
          match_d    = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        // Leave when this edge takes the count to zero (or it already is zero).
        tmr_dec_s = 1'b1;
        if (tmr_expired_s || (tmr_value_s == CW'(1))) begin
          state_d = SAMPLE;
        end else begin
          state_d = SETTLE;
        end
      end
      SAMPLE: begin
        tt_d[stim_q] = resp_in;
        if (stim_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          tv_d    = 1'b1;
          busy_d  = 1'b0;
          stim_d  = '0;
`ifdef TRUTH_TABLE_COMPARE_EN
          match_d = (tt_d == expected_tt);
`endif
        end else begin
          stim_d     = stim_q + NUM_INPUTS'(1);
          tmr_load_s = 1'b1;
          state_d    = HOLD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
      tt_q    <= '0;
`ifdef TRUTH_TABLE_COMPARE_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tv_q    <= tv_d;
      tt_q    <= tt_d;
`ifdef TRUTH_TABLE_COMPARE_EN
      match_q <= match_d;
`endif
    end
  end

  assign stim        = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tt_valid    = tv_q;
  assign truth_table = tt_q;
`ifdef TRUTH_TABLE_COMPARE_EN
  assign match       = match_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 2 and settle 0) against a cycle-count model.
module tb_truth_table_sweeper;

  localparam int TOT_A = 24;
  localparam int TOT_B = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       resp_a, resp_b;
  logic [2:0] stim_a, stim_b;
  logic       busy_a, done_a, tv_a, busy_b, done_b, tv_b;
  logic [7:0] tt_a, tt_b;
`ifdef TRUTH_TABLE_COMPARE_EN
  logic [7:0] exp_a = 8'hAE, exp_b = 8'h5C;
  logic [7:0] xa = 8'h00, xb = 8'h00;
  logic       match_a, match_b;
`endif

  // Model state: c = edges since accepted start (-1 = reset/never started).
  int         ca = -1, cb = -1;
  logic [7:0] fa = 8'hAE, fb = 8'h5C;
  logic [7:0] fra = 8'h00, frb = 8'h00;
  bit         ga = 1'b0, gb = 1'b1;
  int         cyc = 0;
  int         n_tests = 0, n_fail = 0;
  int         dn_a = 0, dc_a = 0, bz_a = 0, dn_b = 0, dc_b = 0, bz_b = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.NUM_INPUTS(3), .SETTLE_CYCLES(2)) u_a (
`ifdef TRUTH_TABLE_COMPARE_EN
    .expected_tt (exp_a),
    .match       (match_a),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .resp_in     (resp_a),
    .stim        (stim_a),
    .busy        (busy_a),
    .done        (done_a),
    .tt_valid    (tv_a),
    .truth_table (tt_a)
  );

  truth_table_sweeper #(.NUM_INPUTS(3), .SETTLE_CYCLES(0)) u_b (
`ifdef TRUTH_TABLE_COMPARE_EN
    .expected_tt (exp_b),
    .match       (match_b),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .resp_in     (resp_b),
    .stim        (stim_b),
    .busy        (busy_b),
    .done        (done_b),
    .tt_valid    (tv_b),
    .truth_table (tt_b)
  );

  // True when the coming edge is a sample edge of an active sweep.
  function automatic bit samp(input int c, input int s, input int tot);
    return (c >= 0) && (c < tot) && (((c + 1) % (s + 1)) == 0);
  endfunction

  // Responding logic: f[stim]; in glitch mode inverted on every non-sample cycle.
  always_comb begin
    resp_a = (samp(ca, 2, TOT_A) || !ga) ? fa[stim_a] : ~fa[stim_a];
    resp_b = (samp(cb, 0, TOT_B) || !gb) ? fb[stim_b] : ~fb[stim_b];
  end

  // Model clock: accept start only when idle, otherwise count edges to completion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca <= -1; cb <= -1; fra <= 8'h00; frb <= 8'h00;
    end else begin
      if ((ca < 0 || ca > TOT_A) && start_a) begin
        ca <= 0; fra <= fa;
`ifdef TRUTH_TABLE_COMPARE_EN
        xa <= exp_a;
`endif
      end else if (ca >= 0 && ca <= TOT_A) ca <= ca + 1;
      if ((cb < 0 || cb > TOT_B) && start_b) begin
        cb <= 0; frb <= fb;
`ifdef TRUTH_TABLE_COMPARE_EN
        xb <= exp_b;
`endif
      end else if (cb >= 0 && cb <= TOT_B) cb <= cb + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_model(input string nm, input int c, input int s, input int tot,
                             input logic [7:0] fr, input logic b, input logic d, input logic v,
                             input logic [2:0] st, input logic [7:0] tt);
    logic eb, ed, ev;
    logic [2:0] es;
    logic [7:0] et;
    int n;
    eb = 1'b0; ed = 1'b0; ev = 1'b0; es = 3'd0; et = 8'h00;
    if (c >= 0 && c < tot) begin
      n  = c / (s + 1);
      eb = 1'b1;
      es = n[2:0];
      et = fr & ((8'd1 << n) - 8'd1);
    end else if (c >= tot) begin
      ed = (c == tot);
      ev = 1'b1;
      et = fr;
    end
    chk({nm, ".busy"}, {31'd0, b}, {31'd0, eb});
    chk({nm, ".done"}, {31'd0, d}, {31'd0, ed});
    chk({nm, ".tt_valid"}, {31'd0, v}, {31'd0, ev});
    chk({nm, ".stim"}, {29'd0, st}, {29'd0, es});
    chk({nm, ".truth_table"}, {24'd0, tt}, {24'd0, et});
  endtask

  task automatic sweep(input bit use_b, input logic [7:0] lit, input bit repulse, input string nm);
    int d0, b0, e0, tot;
    tot = use_b ? TOT_B : TOT_A;
    d0  = use_b ? dn_b : dn_a;
    b0  = use_b ? bz_b : bz_a;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    e0 = cyc;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      start_a = repulse && (i == 4 || i == tot);
    end
    chk({nm, ".done_count"}, (use_b ? dn_b : dn_a) - d0, 1);
    chk({nm, ".done_edge"}, use_b ? dc_b : dc_a, e0 + tot);
    chk({nm, ".busy_cycles"}, (use_b ? bz_b : bz_a) - b0, tot);
    chk({nm, ".table"}, {24'd0, use_b ? tt_b : tt_a}, {24'd0, lit});
    chk({nm, ".tt_valid"}, {31'd0, use_b ? tv_b : tv_a}, 32'd1);
  endtask

  initial begin
    int e0;
    fork
      forever begin
        @(negedge clk);
        check_model("A", ca, 2, TOT_A, fra, busy_a, done_a, tv_a, stim_a, tt_a);
        check_model("B", cb, 0, TOT_B, frb, busy_b, done_b, tv_b, stim_b, tt_b);
`ifdef TRUTH_TABLE_COMPARE_EN
        chk("A.match", {31'd0, match_a}, {31'd0, (ca >= TOT_A) && (fra == xa)});
        chk("B.match", {31'd0, match_b}, {31'd0, (cb >= TOT_B) && (frb == xb)});
`endif
        if (done_a) begin dn_a++; dc_a = cyc; end
        if (done_b) begin dn_b++; dc_b = cyc; end
        if (busy_a) bz_a++;
        if (busy_b) bz_b++;
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    fa = 8'hAE; ga = 1'b0; sweep(1'b0, 8'hAE, 1'b0, "basic");
`ifdef TRUTH_TABLE_COMPARE_EN
    chk("match_hit", {31'd0, match_a}, 32'd1);
`endif
    fa = 8'hFF; sweep(1'b0, 8'hFF, 1'b0, "ones");
    fa = 8'h00; sweep(1'b0, 8'h00, 1'b0, "zeros");
    fa = 8'hAE; sweep(1'b0, 8'hAE, 1'b1, "repulse");

    // Reset mid-sweep, three patterns in.
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    e0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    chk("partial_table", {24'd0, tt_a}, 32'h06);
    rst_n = 1'b0;
    #1;
    chk("rst.busy", {31'd0, busy_a}, 32'd0);
    chk("rst.stim", {29'd0, stim_a}, 32'd0);
    chk("rst.table", {24'd0, tt_a}, 32'd0);
    chk("rst.tt_valid", {31'd0, tv_a}, 32'd0);
    chk("rst.done", {31'd0, done_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sweep(1'b0, 8'hAE, 1'b0, "after_reset");

    ga = 1'b1; sweep(1'b0, 8'hAE, 1'b0, "glitch_a");
    ga = 1'b0;
    fb = 8'h5C; gb = 1'b1; sweep(1'b1, 8'h5C, 1'b0, "settle0");

`ifdef TRUTH_TABLE_COMPARE_EN
    chk("match_b", {31'd0, match_b}, 32'd1);
    exp_a = 8'hAF;
    sweep(1'b0, 8'hAE, 1'b0, "miss");
    chk("match_miss", {31'd0, match_a}, 32'd0);
    exp_a = 8'hAE;
    sweep(1'b0, 8'hAE, 1'b0, "rehit");
    chk("match_rehit", {31'd0, match_a}, 32'd1);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("match_cleared", {31'd0, match_a}, 32'd0);
    repeat (30) @(posedge clk);
`endif

    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
